// File: rtl/dcache_ctrl_if.sv
// Bundles the CPU port, the dcache request port and the memory port of dcache_ctrl.
// The slave modport is the controller's view; master is the view of the surrounding system.
interface dcache_ctrl_if #(
    parameter int ADR_LENGTH  = 32,
    parameter int DATA_LENGTH = 32
);
    logic                   cpu_req_i;
    logic                   cpu_we_i;
    logic [ADR_LENGTH-1:0]  cpu_adr_i;
    logic [DATA_LENGTH-1:0] cpu_dat_i;
    logic [DATA_LENGTH-1:0] cpu_dat_o;
    logic                   cpu_ack_o;
    logic                   cpu_err_o;
    logic                   cpu_busy_o;

    logic                   cc_req_o;
    logic                   cc_we_o;
    logic [ADR_LENGTH-1:0]  cc_adr_o;
    logic [DATA_LENGTH-1:0] cc_dat_o;
    logic                   cc_deload_o;
    logic [DATA_LENGTH-1:0] cache_dat_i;
    logic                   cache_hit_i;
    logic                   cache_free_i;

    logic                   mem_req_o;
    logic                   mem_we_o;
    logic [ADR_LENGTH-1:0]  mem_adr_o;
    logic [DATA_LENGTH-1:0] mem_dat_o;
    logic [DATA_LENGTH-1:0] mem_dat_i;
    logic                   mem_ack_i;

    modport slave (
        input  cpu_req_i, cpu_we_i, cpu_adr_i, cpu_dat_i,
        output cpu_dat_o, cpu_ack_o, cpu_err_o, cpu_busy_o,
        output cc_req_o, cc_we_o, cc_adr_o, cc_dat_o, cc_deload_o,
        input  cache_dat_i, cache_hit_i, cache_free_i,
        output mem_req_o, mem_we_o, mem_adr_o, mem_dat_o,
        input  mem_dat_i, mem_ack_i
    );

    modport master (
        output cpu_req_i, cpu_we_i, cpu_adr_i, cpu_dat_i,
        input  cpu_dat_o, cpu_ack_o, cpu_err_o, cpu_busy_o,
        input  cc_req_o, cc_we_o, cc_adr_o, cc_dat_o, cc_deload_o,
        output cache_dat_i, cache_hit_i, cache_free_i,
        input  mem_req_o, mem_we_o, mem_adr_o, mem_dat_o,
        output mem_dat_i, mem_ack_i
    );
endinterface

// File: rtl/dcache_ctrl.sv
// Write-through, no-write-allocate data cache controller: one CPU access at a time,
// sequenced through lookup, optional eviction, memory access, cache update and response.
module dcache_ctrl #(
    parameter int ADR_LENGTH     = 32,
    parameter int DATA_LENGTH    = 32,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    dcache_ctrl_if.slave         bus,
    output logic [CNT_WIDTH-1:0] hit_cnt_o,
    output logic [CNT_WIDTH-1:0] miss_cnt_o
);

    localparam int TW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [3:0] {
        IDLE,
        LOOKUP,
        CHECK,
        DELOAD,
        MEM_RD,
        FILL,
        MEM_WR,
        CACHE_WR,
        RESP
    } state_e;

    state_e                 state_q;
    logic [ADR_LENGTH-1:0]  adr_q;
    logic [DATA_LENGTH-1:0] storeDat_q;
    logic                   isStore_q;
    logic                   wasHit_q;
    logic [TW-1:0]          timer_q;

    logic [DATA_LENGTH-1:0] cpuDat_q;
    logic                   cpuAck_q;
    logic                   cpuErr_q;
    logic                   busy_q;
    logic                   ccReq_q;
    logic                   ccWe_q;
    logic [ADR_LENGTH-1:0]  ccAdr_q;
    logic [DATA_LENGTH-1:0] ccDat_q;
    logic                   ccDeload_q;
    logic                   memReq_q;
    logic                   memWe_q;
    logic [ADR_LENGTH-1:0]  memAdr_q;
    logic [DATA_LENGTH-1:0] memDat_q;
    logic [CNT_WIDTH-1:0]   hitCnt_q;
    logic [CNT_WIDTH-1:0]   missCnt_q;

    // All outputs are registered and set on entry to the state that owns them, so every
    // strobe is a clean single-cycle pulse and the memory bus is frozen while requesting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            adr_q      <= '0;
            storeDat_q <= '0;
            isStore_q  <= 1'b0;
            wasHit_q   <= 1'b0;
            timer_q    <= '0;
            cpuDat_q   <= '0;
            cpuAck_q   <= 1'b0;
            cpuErr_q   <= 1'b0;
            busy_q     <= 1'b0;
            ccReq_q    <= 1'b0;
            ccWe_q     <= 1'b0;
            ccAdr_q    <= '0;
            ccDat_q    <= '0;
            ccDeload_q <= 1'b0;
            memReq_q   <= 1'b0;
            memWe_q    <= 1'b0;
            memAdr_q   <= '0;
            memDat_q   <= '0;
            hitCnt_q   <= '0;
            missCnt_q  <= '0;
        end else begin
            ccReq_q    <= 1'b0;
            ccWe_q     <= 1'b0;
            ccDeload_q <= 1'b0;
            cpuAck_q   <= 1'b0;
            cpuErr_q   <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (bus.cpu_req_i) begin
                        adr_q      <= bus.cpu_adr_i;
                        storeDat_q <= bus.cpu_dat_i;
                        isStore_q  <= bus.cpu_we_i;
                        ccReq_q    <= 1'b1;
                        ccAdr_q    <= bus.cpu_adr_i;
                        busy_q     <= 1'b1;
                        state_q    <= LOOKUP;
                    end
                end

                LOOKUP: begin
                    state_q <= CHECK;
                end

                CHECK: begin
                    wasHit_q <= bus.cache_hit_i;
                    if (bus.cache_hit_i) begin
                        if (hitCnt_q != '1) hitCnt_q <= hitCnt_q + CNT_WIDTH'(1);
                    end else begin
                        if (missCnt_q != '1) missCnt_q <= missCnt_q + CNT_WIDTH'(1);
                    end

                    // Stores always go to memory; a hit only decides whether the cache copy is updated afterwards.
                    if (isStore_q) begin
                        memReq_q <= 1'b1;
                        memWe_q  <= 1'b1;
                        memAdr_q <= adr_q;
                        memDat_q <= storeDat_q;
                        timer_q  <= '0;
                        state_q  <= MEM_WR;
                    end else if (bus.cache_hit_i) begin
                        cpuDat_q <= bus.cache_dat_i;
                        cpuAck_q <= 1'b1;
                        state_q  <= RESP;
                    end else if (bus.cache_free_i) begin
                        memReq_q <= 1'b1;
                        memWe_q  <= 1'b0;
                        memAdr_q <= adr_q;
                        timer_q  <= '0;
                        state_q  <= MEM_RD;
                    end else begin
                        ccDeload_q <= 1'b1;
                        state_q    <= DELOAD;
                    end
                end

                DELOAD: begin
                    memReq_q <= 1'b1;
                    memWe_q  <= 1'b0;
                    memAdr_q <= adr_q;
                    timer_q  <= '0;
                    state_q  <= MEM_RD;
                end

                MEM_RD: begin
                    if (bus.mem_ack_i) begin
                        memReq_q <= 1'b0;
                        cpuDat_q <= bus.mem_dat_i;
                        ccReq_q  <= 1'b1;
                        ccWe_q   <= 1'b1;
                        ccDat_q  <= bus.mem_dat_i;
                        state_q  <= FILL;
                    end else if (timer_q == TIMER_LAST) begin
                        memReq_q <= 1'b0;
                        cpuDat_q <= '0;
                        cpuErr_q <= 1'b1;
                        cpuAck_q <= 1'b1;
                        state_q  <= RESP;
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end

                FILL: begin
                    cpuAck_q <= 1'b1;
                    state_q  <= RESP;
                end

                MEM_WR: begin
                    if (bus.mem_ack_i) begin
                        memReq_q <= 1'b0;
                        if (wasHit_q) begin
                            ccReq_q <= 1'b1;
                            ccWe_q  <= 1'b1;
                            ccDat_q <= storeDat_q;
                            state_q <= CACHE_WR;
                        end else begin
                            cpuAck_q <= 1'b1;
                            state_q  <= RESP;
                        end
                    end else if (timer_q == TIMER_LAST) begin
                        memReq_q <= 1'b0;
                        cpuDat_q <= '0;
                        cpuErr_q <= 1'b1;
                        cpuAck_q <= 1'b1;
                        state_q  <= RESP;
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end

                CACHE_WR: begin
                    cpuAck_q <= 1'b1;
                    state_q  <= RESP;
                end

                RESP: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end

                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.cpu_dat_o   = cpuDat_q;
    assign bus.cpu_ack_o   = cpuAck_q;
    assign bus.cpu_err_o   = cpuErr_q;
    assign bus.cpu_busy_o  = busy_q;
    assign bus.cc_req_o    = ccReq_q;
    assign bus.cc_we_o     = ccWe_q;
    assign bus.cc_adr_o    = ccAdr_q;
    assign bus.cc_dat_o    = ccDat_q;
    assign bus.cc_deload_o = ccDeload_q;
    assign bus.mem_req_o   = memReq_q;
    assign bus.mem_we_o    = memWe_q;
    assign bus.mem_adr_o   = memAdr_q;
    assign bus.mem_dat_o   = memDat_q;
    assign hit_cnt_o       = hitCnt_q;
    assign miss_cnt_o      = missCnt_q;

endmodule

// File: tb/tb_dcache_ctrl.sv
// Randomised scoreboard bench for dcache_ctrl: the driver predicts each access from the
// cache policy rules, and a monitor checks every CPU response and the bus traffic behind it.
`timescale 1ns/1ps
module tb_dcache_ctrl;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int TO  = 8;
    localparam int CW  = 4;
    localparam int CNT_MAX = (1 << CW) - 1;

    typedef struct {
        logic          isStore;
        logic [AW-1:0] adr;
        logic [DW-1:0] dat;
        logic          hit;
        logic          free;
        logic          timeout;
        int            memWait;
        logic [DW-1:0] cacheDat;
        logic [DW-1:0] memDat;
    } txn_t;

    typedef struct {
        int            startCycle;
        int            latency;
        logic          err;
        logic          checkData;
        logic [DW-1:0] data;
        int            hits;
        int            misses;
        int            deloads;
        int            writes;
        logic [DW-1:0] wrDat;
        int            memCycles;
        logic [AW-1:0] adr;
        logic          isStore;
        logic [DW-1:0] stDat;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [CW-1:0] hitCnt;
    logic [CW-1:0] missCnt;
    int cycleCnt = 0;
    int assertCount = 0;
    int failCount = 0;
    int modelHits = 0;
    int modelMisses = 0;
    int strayCycles = 0;
    logic lateAck = 1'b0;
    exp_t sb[$];
    txn_t cur;

    dcache_ctrl_if #(.ADR_LENGTH(AW), .DATA_LENGTH(DW)) bus ();

    dcache_ctrl #(
        .ADR_LENGTH(AW), .DATA_LENGTH(DW), .TIMEOUT_CYCLES(TO), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus),
        .hit_cnt_o(hitCnt),
        .miss_cnt_o(missCnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
        assertCount++;
        if (act !== req) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic reportExpired(input string name);
        assertCount++;
        failCount++;
        $display("[TB] FAIL %s: wait bound expired, got timeout, expected DUT event", name);
    endtask

    // Expected outcome straight from the policy: which steps an access takes and what it returns.
    function automatic exp_t predict(input txn_t t, input int start);
        exp_t e;
        int w;
        e = '{default: 0};
        w = t.timeout ? TO : t.memWait + 1;
        e.startCycle = start;
        e.adr = t.adr;
        e.isStore = t.isStore;
        e.stDat = t.dat;
        if (t.hit) modelHits = (modelHits < CNT_MAX) ? modelHits + 1 : CNT_MAX;
        else modelMisses = (modelMisses < CNT_MAX) ? modelMisses + 1 : CNT_MAX;
        e.hits = modelHits;
        e.misses = modelMisses;
        if (!t.isStore && t.hit) begin
            e.latency = 3;
            e.checkData = 1'b1;
            e.data = t.cacheDat;
        end else if (!t.isStore) begin
            e.deloads = t.free ? 0 : 1;
            e.memCycles = w;
            e.err = t.timeout;
            e.latency = 4 + e.deloads + w - (t.timeout ? 1 : 0);
            e.checkData = 1'b1;
            e.data = t.timeout ? '0 : t.memDat;
            e.writes = t.timeout ? 0 : 1;
            e.wrDat = t.memDat;
        end else begin
            e.memCycles = w;
            e.err = t.timeout;
            e.writes = (t.hit && !t.timeout) ? 1 : 0;
            e.latency = 3 + w + e.writes;
            e.wrDat = t.dat;
            e.checkData = t.timeout;
            e.data = '0;
        end
        return e;
    endfunction

    function automatic txn_t mkTxn(input logic st, input logic [AW-1:0] adr, input logic [DW-1:0] dat,
                                   input logic hit, input logic free, input logic to, input int w,
                                   input logic [DW-1:0] cacheDat, input logic [DW-1:0] memDat);
        txn_t t;
        t.isStore = st; t.adr = adr; t.dat = dat; t.hit = hit; t.free = free;
        t.timeout = to; t.memWait = w; t.cacheDat = cacheDat; t.memDat = memDat;
        return t;
    endfunction

    function automatic txn_t randTxn();
        return mkTxn(1'($urandom_range(0, 1)), $urandom, $urandom, 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0), $urandom_range(0, 3),
                     $urandom, $urandom);
    endfunction

    // Issue one access once the controller is idle; optionally hold cpu_req_i until the response.
    task automatic applyStimulus(input txn_t t, input bit holdReq);
        int bound = 0;
        @(negedge clk);
        while ((bus.cpu_busy_o || sb.size() != 0) && bound < 300) begin
            @(negedge clk);
            bound++;
        end
        if (bound >= 300) reportExpired("idleWait");
        cur = t;
        bus.cpu_req_i = 1'b1;
        bus.cpu_we_i  = t.isStore;
        bus.cpu_adr_i = t.adr;
        bus.cpu_dat_i = t.dat;
        sb.push_back(predict(t, cycleCnt + 1));
        @(negedge clk);
        if (holdReq) begin
            bound = 0;
            while (!bus.cpu_ack_o && bound < 100) begin
                @(negedge clk);
                bound++;
            end
            if (bound >= 100) reportExpired("heldReqAck");
        end
        bus.cpu_req_i = 1'b0;
        bus.cpu_we_i  = 1'($urandom_range(0, 1));
        bus.cpu_adr_i = $urandom;
        bus.cpu_dat_i = $urandom;
    endtask

    // Dcache model: answers a lookup in the following cycle, garbage at all other times.
    initial begin
        int phase = 0;
        bus.cache_hit_i = 1'b0;
        bus.cache_free_i = 1'b0;
        bus.cache_dat_i = '0;
        forever begin
            @(negedge clk);
            if (bus.cc_req_o && !bus.cc_we_o) begin
                bus.cache_hit_i = cur.hit;
                bus.cache_free_i = cur.free;
                bus.cache_dat_i = cur.cacheDat;
                phase = 1;
            end else if (phase == 1) begin
                phase = 0;
            end else begin
                bus.cache_hit_i = 1'($urandom_range(0, 1));
                bus.cache_free_i = 1'($urandom_range(0, 1));
                bus.cache_dat_i = $urandom;
            end
        end
    end

    // Memory model: acks in request cycle memWait+1 unless the access is meant to time out.
    initial begin
        int k = 0;
        bus.mem_ack_i = 1'b0;
        bus.mem_dat_i = '0;
        forever begin
            @(negedge clk);
            if (bus.mem_req_o) begin
                k++;
                bus.mem_ack_i = (k == cur.memWait + 1) && !cur.timeout;
                bus.mem_dat_i = bus.mem_ack_i ? cur.memDat : $urandom;
            end else begin
                k = 0;
                bus.mem_ack_i = lateAck;
                bus.mem_dat_i = $urandom;
            end
        end
    end

    // Monitor: accumulates bus traffic for the access in flight and scores it at cpu_ack_o.
    initial begin
        int lookups = 0, deloads = 0, writes = 0, memCycles = 0;
        logic [DW-1:0] wrDat = '0;
        bit ccBad = 0, memBad = 0, orderBad = 0, prevDeload = 0, prevMemReq = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                lookups = 0; deloads = 0; writes = 0; memCycles = 0;
                ccBad = 0; memBad = 0; orderBad = 0; prevDeload = 0; prevMemReq = 0;
                continue;
            end
            if (bus.cc_req_o || bus.cc_deload_o)
                checkOutput("ccReqDeloadExclusive", 64'(bus.cc_req_o & bus.cc_deload_o), 64'(0));
            if (sb.size() > 0) begin
                if ((bus.cc_req_o || bus.cc_deload_o) && bus.cc_adr_o !== sb[0].adr) ccBad = 1;
                if (bus.mem_req_o) begin
                    if (bus.mem_adr_o !== sb[0].adr || bus.mem_we_o !== sb[0].isStore ||
                        (sb[0].isStore && bus.mem_dat_o !== sb[0].stDat)) memBad = 1;
                    if (!prevMemReq && sb[0].deloads == 1 && !prevDeload) orderBad = 1;
                end
            end else if (bus.cc_req_o || bus.cc_deload_o || bus.mem_req_o) begin
                strayCycles++;
            end
            if (bus.cc_req_o && !bus.cc_we_o) lookups++;
            if (bus.cc_req_o && bus.cc_we_o) begin
                writes++;
                wrDat = bus.cc_dat_o;
            end
            if (bus.cc_deload_o) deloads++;
            if (bus.mem_req_o) memCycles++;
            prevDeload = bus.cc_deload_o;
            prevMemReq = bus.mem_req_o;
            if (bus.cpu_ack_o) begin
                if (sb.size() == 0) begin
                    reportExpired("unexpectedAck");
                end else begin
                    e = sb.pop_front();
                    checkOutput("latency", 64'(cycleCnt - e.startCycle + 1), 64'(e.latency));
                    checkOutput("cpuErr", 64'(bus.cpu_err_o), 64'(e.err));
                    checkOutput("busyAtAck", 64'(bus.cpu_busy_o), 64'(1));
                    if (e.checkData) checkOutput("cpuDat", 64'(bus.cpu_dat_o), 64'(e.data));
                    checkOutput("hitCnt", 64'(hitCnt), 64'(e.hits));
                    checkOutput("missCnt", 64'(missCnt), 64'(e.misses));
                    checkOutput("lookupPulses", 64'(lookups), 64'(1));
                    checkOutput("deloadPulses", 64'(deloads), 64'(e.deloads));
                    checkOutput("cacheWritePulses", 64'(writes), 64'(e.writes));
                    if (e.writes > 0) checkOutput("cacheWriteDat", 64'(wrDat), 64'(e.wrDat));
                    checkOutput("memReqCycles", 64'(memCycles), 64'(e.memCycles));
                    checkOutput("memBusStable", 64'(memBad), 64'(0));
                    checkOutput("ccAddress", 64'(ccBad), 64'(0));
                    checkOutput("deloadBeforeMemReq", 64'(orderBad), 64'(0));
                end
                lookups = 0; deloads = 0; writes = 0; memCycles = 0;
                ccBad = 0; memBad = 0; orderBad = 0;
            end
        end
    end

    initial begin
        #400000;
        $display("[TB] FAIL globalWatchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int bound;
        logic activity;
        bus.cpu_req_i = 1'b0;
        bus.cpu_we_i  = 1'b0;
        bus.cpu_adr_i = '0;
        bus.cpu_dat_i = '0;
        repeat (3) @(negedge clk);
        checkOutput("resetOutputsZero", 64'(|{bus.cpu_dat_o, bus.cpu_ack_o, bus.cpu_err_o, bus.cpu_busy_o,
                    bus.cc_req_o, bus.cc_we_o, bus.cc_adr_o, bus.cc_dat_o, bus.cc_deload_o, bus.mem_req_o,
                    bus.mem_we_o, bus.mem_adr_o, bus.mem_dat_o, hitCnt, missCnt}), 64'(0));
        rst_n = 1'b1;

        $display("[TB] directed accesses");
        applyStimulus(mkTxn(0, 32'h0000_1000, 32'h0, 1, 0, 0, 0, 32'hEA99A94A, 32'h0), 0);
        applyStimulus(mkTxn(0, 32'h00CC3FC3, 32'h0, 0, 1, 0, 2, 32'h1234_5678, 32'h140FFE3F), 0);
        applyStimulus(mkTxn(0, 32'h00CC3B43, 32'h0, 0, 0, 0, 1, 32'h0, 32'hA5A5_0F0F), 0);
        applyStimulus(mkTxn(1, 32'h0000_2004, 32'h0001FFF5, 1, 0, 0, 1, 32'h0, 32'h0), 0);
        applyStimulus(mkTxn(1, 32'h0000_3008, 32'hDEAD_BEEF, 0, 1, 0, 0, 32'h0, 32'h0), 0);
        applyStimulus(mkTxn(0, 32'h0000_400C, 32'h0, 0, 1, 1, 0, 32'h0, 32'h5555_AAAA), 0);
        applyStimulus(mkTxn(1, 32'h0000_5010, 32'h0BAD_F00D, 1, 1, 1, 0, 32'h0, 32'h0), 0);
        applyStimulus(mkTxn(0, 32'h0000_6014, 32'h0, 1, 0, 0, 0, 32'hC0FF_EE00, 32'h0), 1);
        repeat (3) @(negedge clk);
        checkOutput("reqHeldNotReaccepted", 64'(bus.cpu_busy_o), 64'(0));

        $display("[TB] random accesses");
        for (int i = 0; i < 40; i++) applyStimulus(randTxn(), 0);

        $display("[TB] counter saturation");
        for (int i = 0; i < CNT_MAX + 1; i++)
            applyStimulus(mkTxn(0, $urandom, 32'h0, 1, 0, 0, 0, $urandom, 32'h0), 0);
        for (int i = 0; i < CNT_MAX + 1; i++)
            applyStimulus(mkTxn(1, $urandom, $urandom, 0, 0, 0, 0, 32'h0, 32'h0), 0);

        $display("[TB] reset during memory read");
        applyStimulus(mkTxn(0, 32'h0000_7018, 32'h0, 0, 1, 0, 5, 32'h0, 32'h7777_8888), 0);
        bound = 0;
        while (!bus.mem_req_o && bound < 50) begin
            @(negedge clk);
            bound++;
        end
        if (bound >= 50) reportExpired("memReqBeforeReset");
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("asyncResetOutputsZero", 64'(|{bus.cpu_dat_o, bus.cpu_ack_o, bus.cpu_err_o, bus.cpu_busy_o,
                    bus.cc_req_o, bus.cc_we_o, bus.cc_adr_o, bus.cc_dat_o, bus.cc_deload_o, bus.mem_req_o,
                    bus.mem_we_o, bus.mem_adr_o, bus.mem_dat_o, hitCnt, missCnt}), 64'(0));
        sb.delete();
        modelHits = 0;
        modelMisses = 0;
        @(negedge clk);
        rst_n = 1'b1;
        lateAck = 1'b1;
        @(negedge clk);
        lateAck = 1'b0;
        activity = 1'b0;
        repeat (10) begin
            @(negedge clk);
            activity |= bus.cpu_busy_o | bus.cpu_ack_o | bus.mem_req_o | bus.cc_req_o | bus.cc_deload_o;
        end
        checkOutput("quietAfterLateAck", 64'(activity), 64'(0));
        checkOutput("strayBusActivity", 64'(strayCycles), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
